// File: rtl/abs_accum_ctrl_pkg.sv
// Shared definitions for the block-magnitude accumulator: sample width and FSM states.
package abs_accum_ctrl_pkg;

  localparam int SAMPLE_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/abs_accum_ctrl_absolute.sv
// Combinational magnitude of a signed two's-complement sample.
// The result is read as unsigned, so the most negative input maps to 2^(SAMPLE_W-1).
module absolute
  import abs_accum_ctrl_pkg::*;
(
  input  logic [SAMPLE_W-1:0] x,
  output logic [SAMPLE_W-1:0] y
);

  assign y = x[SAMPLE_W-1] ? (~x + SAMPLE_W'(1)) : x;

endmodule

// File: rtl/abs_accum_ctrl.sv
// Streams signed samples through one shared absolute unit and reports the L1 sum
// and peak magnitude of each N_SAMPLES block over a valid/ready output handshake.
module abs_accum_ctrl
  import abs_accum_ctrl_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = 3,
  parameter int ACC_W     = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_sum,
  output logic [SAMPLE_W-1:0] out_max,
  output logic                busy
);

  if (N_SAMPLES < 2 || (2 ** CNT_W) < N_SAMPLES ||
      ACC_W < SAMPLE_W + $clog2(N_SAMPLES)) begin : g_bad_params
    $error("abs_accum_ctrl: illegal N_SAMPLES/CNT_W/ACC_W combination");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    count;
  logic [ACC_W-1:0]    acc;
  logic [SAMPLE_W-1:0] maxv;
  logic [SAMPLE_W-1:0] mag;
  logic [ACC_W-1:0]    acc_upd;
  logic [SAMPLE_W-1:0] max_upd;
  logic                accept;

  absolute u_absolute (
    .x (in_data),
    .y (mag)
  );

  assign in_ready  = (state == ST_RUN);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  assign acc_upd = acc + ACC_W'(mag);
  assign max_upd = (mag > maxv) ? mag : maxv;

  // start is only looked at in IDLE, so pulses in RUN or DONE never restart a block.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: state_next = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_next = (accept && count == LAST) ? ST_DONE : ST_RUN;
      ST_DONE: state_next = out_ready ? ST_IDLE : ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      acc     <= '0;
      maxv    <= '0;
      out_sum <= '0;
      out_max <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) begin
        count <= '0;
        acc   <= '0;
        maxv  <= '0;
      end else if (accept) begin
        acc  <= acc_upd;
        maxv <= max_upd;
        if (count == LAST) begin
          count   <= '0;
          out_sum <= acc_upd;
          out_max <= max_upd;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_abs_accum_ctrl.sv
// Self-checking bench for abs_accum_ctrl: a table of directed vectors for one full block,
// then hand-written sequences for gaps, output backpressure, aborts and ignored starts.
module tb_abs_accum_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_sum;
  logic [5:0] out_max;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       start;
    logic       in_valid;
    logic [5:0] in_data;
    logic       out_ready;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic       exp_busy;
    logic [8:0] exp_sum;
    logic [5:0] exp_max;
  } vec_t;

  vec_t vecs[10];

  abs_accum_ctrl #(
    .N_SAMPLES (8),
    .CNT_W     (3),
    .ACC_W     (9)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_max   (out_max),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge sample them, and settle 1 ns past it.
  task automatic applyStimulus(input logic st, input logic iv, input logic [5:0] d,
                               input logic ordy);
    start     = st;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic rdy, input logic vld,
                          input logic bsy, input logic [8:0] s, input logic [5:0] m);
    checkOutput({tag, ".in_ready"},  16'(in_ready),  16'(rdy));
    checkOutput({tag, ".out_valid"}, 16'(out_valid), 16'(vld));
    checkOutput({tag, ".busy"},      16'(busy),      16'(bsy));
    checkOutput({tag, ".out_sum"},   16'(out_sum),   16'(s));
    checkOutput({tag, ".out_max"},   16'(out_max),   16'(m));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Block {3,-3,5,-1,0,31,-32,2}: sum 77, max 32; then handshake back to IDLE.
    vecs[0] = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0,  6'd0};
    vecs[1] = '{1'b0, 1'b1, 6'h03, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0,  6'd0};
    vecs[2] = '{1'b0, 1'b1, 6'h3D, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0,  6'd0};
    vecs[3] = '{1'b0, 1'b1, 6'h05, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0,  6'd0};
    vecs[4] = '{1'b0, 1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0,  6'd0};
    vecs[5] = '{1'b0, 1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0,  6'd0};
    vecs[6] = '{1'b0, 1'b1, 6'h1F, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0,  6'd0};
    vecs[7] = '{1'b0, 1'b1, 6'h20, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0,  6'd0};
    vecs[8] = '{1'b0, 1'b1, 6'h02, 1'b0, 1'b0, 1'b1, 1'b1, 9'd77, 6'd32};
    vecs[9] = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 9'd77, 6'd32};

    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 6'h05, 1'b1);
    checkAll("reset", 1'b0, 1'b0, 1'b0, 9'd0, 6'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].start, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
               vecs[i].exp_busy, vecs[i].exp_sum, vecs[i].exp_max);
    end

    // Samples of 7 separated by 1-3 idle cycles: sum 56, max 7.
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 3) + 1; g++) begin
        applyStimulus(1'b0, 1'b0, 6'h07, 1'b0);
        checkOutput($sformatf("gap%0d_%0d.in_ready", i, g), 16'(in_ready), 16'd1);
        checkOutput($sformatf("gap%0d_%0d.out_valid", i, g), 16'(out_valid), 16'd0);
      end
      applyStimulus(1'b0, 1'b1, 6'h07, 1'b0);
    end
    checkAll("gaps_done", 1'b0, 1'b1, 1'b1, 9'd56, 6'd7);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1);
    checkAll("gaps_idle", 1'b0, 1'b0, 1'b0, 9'd56, 6'd7);

    // Samples 1..8 (sum 36, max 8), then 5 cycles of backpressure with stray samples.
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 6'(i + 1), 1'b0);
    checkAll("hold_entry", 1'b0, 1'b1, 1'b1, 9'd36, 6'd8);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 6'h1F, 1'b0);
      checkAll($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b1, 9'd36, 6'd8);
    end
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1);
    checkAll("hold_release", 1'b0, 1'b0, 1'b0, 9'd36, 6'd8);
    applyStimulus(1'b0, 1'b1, 6'h1F, 1'b0);
    checkAll("idle_ignores_valid", 1'b0, 1'b0, 1'b0, 9'd36, 6'd8);

    // Abort after 4 samples of 10, then a clean block of eight -1 samples.
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 6'd10, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 6'd10, 1'b0);
    reset = 1'b0;
    checkAll("abort", 1'b0, 1'b0, 1'b0, 9'd0, 6'd0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0);
    checkAll("abort_idle", 1'b0, 1'b0, 1'b0, 9'd0, 6'd0);
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 6'h3F, 1'b0);
    checkAll("after_abort", 1'b0, 1'b1, 1'b1, 9'd8, 6'd1);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1);

    // Start pulses in RUN and in the DONE handshake cycle must be ignored.
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 6'd4, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0);
    checkAll("start_in_run", 1'b1, 1'b0, 1'b1, 9'd8, 6'd1);
    applyStimulus(1'b1, 1'b1, 6'd4, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 6'd4, 1'b0);
    checkAll("restart_done", 1'b0, 1'b1, 1'b1, 9'd32, 6'd4);
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b1);
    checkAll("start_in_handshake", 1'b0, 1'b0, 1'b0, 9'd32, 6'd4);
    applyStimulus(1'b0, 1'b1, 6'd4, 1'b0);
    checkAll("idle_wait", 1'b0, 1'b0, 1'b0, 9'd32, 6'd4);
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0);
    checkAll("fresh_start", 1'b1, 1'b0, 1'b1, 9'd32, 6'd4);

    // The block just started carries eight -32 samples: worst-case sum 256.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 6'h20, 1'b0);
    checkAll("all_min", 1'b0, 1'b1, 1'b1, 9'd256, 6'd32);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b1);
    checkAll("all_min_idle", 1'b0, 1'b0, 1'b0, 9'd256, 6'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/abs_accum_ctrl.md
Name: abs_accum_ctrl

Overview:
- Sequencer that streams signed 6-bit two's-complement samples through one shared `absolute` unit.
- Accumulates the L1 sum and the running maximum magnitude over a fixed block of N_SAMPLES, then presents both results through a valid/ready output handshake.
- Sits between a sample producer (e.g. a difference/error stage) and any consumer needing block magnitude statistics.

Parameters:
- N_SAMPLES, 8: samples per block; legal range >= 2.
- CNT_W, 3: sample counter width; must satisfy 2^CNT_W >= N_SAMPLES.
- ACC_W, 9: accumulator width; must be >= 6 + ceil(log2(N_SAMPLES)) so that N_SAMPLES*32 never overflows.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a block; honoured only in IDLE.
- in_valid  input  1  producer has a sample on in_data.
- in_data  input  6  signed two's-complement sample.
- in_ready  output  1  block accepts a sample this cycle.
- out_valid  output  1  results are valid.
- out_ready  input  1  consumer takes the results.
- out_sum  output  ACC_W  unsigned sum of |in_data| over the block.
- out_max  output  6  unsigned maximum |in_data| over the block.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset: state=IDLE; count=0, acc=0, maxv=0; in_ready=0, out_valid=0, busy=0, out_sum=0, out_max=0. Reset applied mid-block or mid-DONE discards all partial results; no out_valid follows.
- Magnitude: in_data drives the `absolute` instance combinationally. Its 6-bit result is always interpreted as unsigned.
  - |-32| (6'b100000) = 32.
  - |-1| = 1, |0| = 0, |+31| = 31.
- Accept condition: accept = in_valid & in_ready. in_ready = (state==RUN), decoded from the state register only; it never depends on in_valid.
- IDLE:
  - start=1 -> RUN next cycle; clear count, acc and maxv in the same edge.
  - in_valid is ignored in IDLE.
- RUN, on each accept:
  - acc <= acc + zero-extended |x|.
  - maxv <= max(maxv, |x|).
  - count <= count + 1.
  - On the accept with count == N_SAMPLES-1: go to DONE next cycle and register out_sum/out_max from the updated values. Do not increment count past N_SAMPLES-1; count returns to 0.
  - Gaps: in_valid=0 cycles stall without changing state.
  - start is ignored in RUN (no restart).
- DONE:
  - out_valid=1; out_sum and out_max are held stable while out_valid=1 & out_ready=0.
  - in_ready=0.
  - out_valid & out_ready -> IDLE next cycle; out_valid drops there.
  - start during DONE is ignored, including in the same cycle as the completing handshake; start must be re-pulsed in IDLE.
- Latency:
  - out_valid asserts exactly 1 cycle after the edge that accepts the Nth sample.
  - Minimum block time: 1 (start) + N_SAMPLES + 1 cycles to out_valid.
- Outputs out_sum and out_max retain the last block's values in IDLE and update only on entry to DONE.
- Arithmetic: all widths are unsigned; no saturation is needed given the ACC_W rule. Illegal parameter combinations are caught by an elaboration-time check.
- Unused state encoding -> IDLE.

Decomposition:
- Shared package/include holds:
  - state localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - SAMPLE_W=6.
- One sub-module: the existing `absolute` block, instantiated once with x=in_data. All sequencing, counter, accumulator and max logic live in abs_accum_ctrl.

Test Plan:
- Reset, then start. Feed 8 back-to-back samples {3,-3,5,-1,0,31,-32,2} -> out_valid at cycle 10 after start; out_sum=77, out_max=32.
- Insert in_valid gaps of 1-3 cycles between samples, all inputs 7 -> out_sum=56, out_max=7; in_ready stays high through the gaps; no sample is double-counted.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_max are stable; in_ready=0; extra in_valid pulses are not accepted. Then raise out_ready -> IDLE next cycle.
- Assert reset after 4 accepted samples -> all outputs return to reset values the next cycle. A new start plus 8 samples of -1 -> out_sum=8, out_max=1, with no contamination from the aborted block.
- Pulse start during RUN and during the DONE handshake cycle -> no restart; the block completes normally; the FSM sits in IDLE until a fresh start.
- All samples -32 -> out_sum=256 (no overflow at ACC_W=9), out_max=32.
